fetch_queue: RTL and testbench

Instruction fetch queue between the PC generator and decode. Each cycle it takes the current PC, issues an instruction-memory read for it, and holds the PC/instruction pairs in an in-order ring buffer until decode accepts them. It stalls the PC generator when no request can be issued. On a control-flow redirect it discards buffered and in-flight instructions.

---
 rtl/fetch_queue.sv | 133 +++++++++++++
 tb/tb_fetch_queue.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ==========================================================================
// fetch_queue : in-order PC/instruction ring buffer between PC gen and decode
// Option      : FETCH_QUEUE_MISALIGN_CHECK_EN adds out_fault (misaligned PC)
// Revision    : 1.0
// ==========================================================================
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        stall_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
  output logic        out_fault,
`endif
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] c_depth = DEPTH[CW:0];
  localparam logic [31:0] c_nop   = 32'h0000_0013;

  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_drop;

  logic          w_misalign;
  logic          w_room;
  logic          w_alloc;
  logic          w_req_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_rsp_take;
  logic          w_fill_found;
  logic [PW-1:0] w_fill_idx;
  logic [CW-1:0] w_unfilled;

`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
  logic [DEPTH-1:0] r_fault;
  assign w_misalign = (pc_in[1:0] != 2'b00);
  assign out_fault  = out_valid && r_fault[r_head];
`else
  assign w_misalign = 1'b0;
`endif

  // Outstanding reads include responses already owed to cancelled requests.
  assign w_room         = ({1'b0, r_count} + {1'b0, r_drop}) < c_depth;
  assign w_alloc        = !reset && !flush && w_room;
  assign imem_req_valid = w_alloc && !w_misalign;
  assign imem_req_addr  = pc_in;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_push         = w_req_fire || (w_alloc && w_misalign);
  assign stall_en       = reset || (!w_push && !flush);

  assign out_valid = (r_count != '0) && r_filled[r_head];
  assign out_pc    = out_valid ? r_pc[r_head]    : '0;
  assign out_instr = out_valid ? r_instr[r_head] : '0;
  assign w_pop     = out_valid && out_ready;

  // Oldest unfilled live entry, and how many live entries still await data.
  always_comb begin
    w_fill_found = 1'b0;
    w_fill_idx   = r_head;
    w_unfilled   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) && !r_filled[r_head + PW'(k)]) begin
        w_unfilled = w_unfilled + CW'(1);
        if (!w_fill_found) begin
          w_fill_found = 1'b1;
          w_fill_idx   = r_head + PW'(k);
        end
      end
    end
  end

  assign w_rsp_take = imem_rsp_valid && (r_drop == '0) && w_fill_found;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_filled <= '0;
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
      r_fault  <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
      if (reset) r_drop <= '0;
      else       r_drop <= r_drop + w_unfilled - CW'(imem_rsp_valid);
    end else begin
      if (w_rsp_take) begin
        r_instr[w_fill_idx]  <= imem_rsp_data;
        r_filled[w_fill_idx] <= 1'b1;
      end
      if (imem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
      if (w_push) begin
        r_pc[r_tail]     <= pc_in;
        r_instr[r_tail]  <= w_misalign ? c_nop : '0;
        r_filled[r_tail] <= w_misalign;
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
        r_fault[r_tail]  <= w_misalign;
`endif
        r_tail           <= r_tail + PW'(1);
      end
      if (w_pop) r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// Testbench for fetch_queue: bench-side memory model and PC generator with a
// scoreboard of expected PC/instruction pairs popped as decode accepts them.
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        flush;
  logic        stall_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
  logic        out_fault;
`endif

  fetch_queue #(.DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc_in          (pc_in),
    .flush          (flush),
    .stall_en       (stall_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
    .out_fault      (out_fault),
`endif
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; int due; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mem_t        pend[$];
  exp_t        sb[$];
  logic [31:0] popped[$];
  logic [31:0] flush_target;
  int          cyc, lat, n_req, n_pop;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        cap_stall, cap_req_valid;

  // One clock cycle: memory answers, outputs are scored, PC generator steps.
  task automatic cycle();
    exp_t e;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend[0].addr ^ 32'hA5A5_A5A5;
      void'(pend.pop_front());
    end
    #1;
    cap_stall     = stall_en;
    cap_req_valid = imem_req_valid;
    if (imem_req_valid) begin
      n_checks++;
      if (imem_req_addr !== pc_in) begin
        n_fail++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, pc_in);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      pend.push_back('{imem_req_addr, cyc + lat});
      sb.push_back('{pc_in, pc_in ^ 32'hA5A5_A5A5});
      n_req++;
    end
    if (flush) begin
      sb.delete();
    end else if (out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pop cyc=%0d got pc=%h exp=no entry", cyc, out_pc);
      end else begin
        e = sb.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          n_fail++;
          $display("FAIL pop_data cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                   cyc, out_pc, out_instr, e.pc, e.instr);
        end
        popped.push_back(out_pc);
        n_pop++;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    if (flush)           pc_in = flush_target;
    else if (!cap_stall) pc_in = pc_in + 32'd4;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; pc_in = '0; out_ready = 1'b1;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    pend.delete(); sb.delete(); popped.delete();
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0; cyc = 0; n_req = 0; n_pop = 0; lat = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; pc_in = 32'h40; out_ready = 1'b1;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    n_checks++;
    if (imem_req_valid !== 1'b0 || stall_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_req got valid=%b stall=%b exp valid=0 stall=1", imem_req_valid, stall_en);
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out got v=%b pc=%h instr=%h exp 0/0/0", out_valid, out_pc, out_instr);
    end
    n_checks++;
    if (dut.r_count !== 3'd0 || dut.r_drop !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_counts got count=%0d drop=%0d exp 0/0", dut.r_count, dut.r_drop);
    end
  endtask

  task automatic test_stream();
    int first_valid;
    do_reset();
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || stall_en !== 1'b0) begin
      n_fail++;
      $display("FAIL first_req got valid=%b addr=%h stall=%b exp 1/0/0", imem_req_valid, imem_req_addr, stall_en);
    end
    first_valid = -1;
    for (int i = 0; i < 14; i++) begin
      if (out_valid && first_valid < 0) first_valid = cyc;
      cycle();
      if (i == 6) begin
        n_checks++;
        if (cap_stall !== 1'b0) begin
          n_fail++;
          $display("FAIL steady_stall got=%b exp=0", cap_stall);
        end
      end
    end
    n_checks++;
    if (first_valid != 2) begin
      n_fail++;
      $display("FAIL first_out_cycle got=%0d exp=2", first_valid);
    end
    n_checks++;
    if (n_pop != 12) begin
      n_fail++;
      $display("FAIL stream_pops got=%0d exp=12", n_pop);
    end
    n_checks++;
    if (popped.size() < 2 || popped[0] !== 32'h0 || popped[1] !== 32'h4) begin
      n_fail++;
      $display("FAIL stream_order got n=%0d exp first pcs 0,4", popped.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    n_checks++;
    if (n_req != 4) begin
      n_fail++;
      $display("FAIL full_reqs got=%0d exp=4", n_req);
    end
    n_checks++;
    if (imem_req_valid !== 1'b0 || stall_en !== 1'b1) begin
      n_fail++;
      $display("FAIL full_stall got valid=%b stall=%b exp 0/1", imem_req_valid, stall_en);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_no_issue got=%b exp=0", imem_req_valid);
    end
    for (int i = 0; i < 8; i++) cycle();
    exp_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (popped.size() <= i || popped[i] !== exp_pc) begin
        n_fail++;
        $display("FAIL drain_order idx=%0d got n=%0d exp pc=%h", i, popped.size(), exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_req_stall();
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (cap_stall !== 1'b1 || pc_in !== 32'h0) begin
        n_fail++;
        $display("FAIL not_ready_stall i=%0d got stall=%b pc=%h exp 1/0", i, cap_stall, pc_in);
      end
    end
    n_checks++;
    if (dut.r_count !== 3'd0) begin
      n_fail++;
      $display("FAIL not_ready_alloc got count=%0d exp=0", dut.r_count);
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    n_checks++;
    if (popped.size() == 0 || popped[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL not_ready_resume got n=%0d exp first pc=0", popped.size());
    end
  endtask

  task automatic test_flush();
    do_reset();
    lat = 3;
    cycle();
    cycle();
    flush = 1'b1;
    flush_target = 32'h100;
    cycle();
    n_checks++;
    if (cap_req_valid !== 1'b0 || cap_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle got valid=%b stall=%b exp 0/0", cap_req_valid, cap_stall);
    end
    n_checks++;
    if (dut.r_drop !== 3'd2) begin
      n_fail++;
      $display("FAIL flush_drop got=%0d exp=2", dut.r_drop);
    end
    for (int i = 0; i < 10; i++) cycle();
    n_checks++;
    if (popped.size() == 0 || popped[0] !== 32'h100) begin
      n_fail++;
      $display("FAIL flush_redirect got n=%0d exp first pc=100", popped.size());
    end
  endtask

  task automatic test_flush_rsp_pop();
    bit done;
    do_reset();
    lat = 3;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (out_valid && pend.size() > 0 && pend[0].due <= cyc) begin
        flush = 1'b1;
        flush_target = 32'h200;
        done = 1'b1;
      end
      cycle();
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL flush_rsp_timeout got=no overlap exp=overlap within 20 cycles");
    end else begin
      if (dut.r_count !== 3'd0 || dut.r_drop !== 3'd2 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_rsp_state got count=%0d drop=%0d v=%b exp 0/2/0",
                 dut.r_count, dut.r_drop, out_valid);
      end
    end
    for (int i = 0; i < 12; i++) cycle();
    n_checks++;
    if (popped.size() == 0 || popped[0] !== 32'h200) begin
      n_fail++;
      $display("FAIL flush_rsp_redirect got n=%0d exp first pc=200", popped.size());
    end
  endtask

`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
  task automatic test_misalign();
    do_reset();
    out_ready = 1'b0;
    pc_in = 32'h2;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0 || stall_en !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_req got valid=%b stall=%b exp 0/0", imem_req_valid, stall_en);
    end
    @(posedge clock); #1;
    imem_req_ready = 1'b0;
    pc_in = 32'h8;
    n_checks++;
    if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_instr !== 32'h13 || out_pc !== 32'h2) begin
      n_fail++;
      $display("FAIL misalign_out got v=%b f=%b instr=%h pc=%h exp 1/1/00000013/2",
               out_valid, out_fault, out_instr, out_pc);
    end
  endtask
`endif

  initial begin
    lat = 1;
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_flush();
    test_flush_rsp_pop();
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
